// File: rtl/inst_mem_seq_if.sv
// Fetch request/response bundle between the PC/fetch stage and the instruction memory.
// Master drives request and address; slave returns ready, a one-cycle valid pulse, word and fault.
interface inst_mem_seq_if #(
    parameter int ADDR_W = 32
);
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ready;
    logic              fetch_valid;
    logic [31:0]       fetch_inst;
    logic              fetch_fault;

    modport master (
        output fetch_req,
        output fetch_addr,
        input  fetch_ready,
        input  fetch_valid,
        input  fetch_inst,
        input  fetch_fault
    );

    modport slave (
        input  fetch_req,
        input  fetch_addr,
        output fetch_ready,
        output fetch_valid,
        output fetch_inst,
        output fetch_fault
    );
endinterface

// File: rtl/inst_mem_seq.sv
// Synchronous instruction memory: loadable array, fault checks, optional prefetch buffer (IMEM_PREFETCH_EN).
// Latency WAIT_CYCLES+1 (1 on a prefetch hit); no response backpressure, requests held until fetch_ready.
module inst_mem_seq #(
    parameter int  DEPTH       = 32,
    parameter int  ADDR_W      = 32,
    parameter int  WAIT_CYCLES = 0,
    localparam int IDX_W       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    inst_mem_seq_if.slave    fif,
    input  logic             i_ld_we,
    input  logic [IDX_W-1:0] i_ld_idx,
    input  logic [31:0]      i_ld_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    logic [31:0]       r_mem [DEPTH];
    state_t            r_state;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_valid;
    logic [31:0]       r_inst;
    logic              r_fault;

    logic [IDX_W-1:0]  w_idx;
    logic              w_fault;
    logic [31:0]       w_word;
    logic              w_hit;

    // Anything above the top word index is out of range, so test the high bits directly.
    assign w_idx   = r_addr[IDX_W+1:2];
    assign w_fault = (r_addr[1:0] != 2'b00) || ((r_addr >> (IDX_W + 2)) != '0);

`ifdef IMEM_PREFETCH_EN
    logic              r_pf_vld;
    logic [IDX_W-1:0]  r_pf_tag;
    logic [31:0]       r_pf_word;
    logic              r_hit;

    logic [IDX_W-1:0]  w_req_idx;
    logic              w_req_ok;
    logic [IDX_W-1:0]  w_nidx;
    logic              w_cap;

    assign w_req_idx = fif.fetch_addr[IDX_W+1:2];
    assign w_req_ok  = (fif.fetch_addr[1:0] == 2'b00) &&
                       ((fif.fetch_addr >> (IDX_W + 2)) == '0);
    // A load to the tagged word in the acceptance cycle must not be served stale.
    assign w_hit     = r_pf_vld && w_req_ok && (w_req_idx == r_pf_tag) &&
                       !(i_ld_we && (i_ld_idx == r_pf_tag));
    assign w_nidx    = w_idx + {{(IDX_W-1){1'b0}}, 1'b1};
    assign w_cap     = (r_state == S_RESP) && !w_fault && (w_idx != IDX_W'(DEPTH - 1));
    assign w_word    = r_hit ? r_pf_word : r_mem[w_idx];
`else
    assign w_hit     = 1'b0;
    assign w_word    = r_mem[w_idx];
`endif

    // Array is deliberately unreset; reads elsewhere see the pre-write word on a same-edge load.
    always_ff @(posedge clk) begin
        if (i_ld_we) begin
            r_mem[i_ld_idx] <= i_ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_valid <= 1'b0;
            r_inst  <= 32'h0000_0000;
            r_fault <= 1'b0;
`ifdef IMEM_PREFETCH_EN
            r_hit   <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (fif.fetch_req) begin
                        r_addr <= fif.fetch_addr;
`ifdef IMEM_PREFETCH_EN
                        r_hit  <= w_hit;
`endif
                        if (w_hit || (WAIT_CYCLES == 0)) begin
                            r_state <= S_RESP;
                        end else begin
                            r_cnt   <= 4'(WAIT_CYCLES - 1);
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_valid <= 1'b1;
                    r_fault <= w_fault;
                    r_inst  <= w_fault ? 32'h0000_0000 : w_word;
                    r_state <= S_IDLE;
`ifdef IMEM_PREFETCH_EN
                    r_hit   <= 1'b0;
`endif
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef IMEM_PREFETCH_EN
    // Capture the next sequential word on each good response; any load to the tag kills it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pf_vld  <= 1'b0;
            r_pf_tag  <= '0;
            r_pf_word <= 32'h0000_0000;
        end else if ((r_state == S_RESP) && w_fault) begin
            r_pf_vld  <= 1'b0;
        end else if (w_cap) begin
            r_pf_vld  <= !(i_ld_we && (i_ld_idx == w_nidx));
            r_pf_tag  <= w_nidx;
            r_pf_word <= r_mem[w_nidx];
        end else if (i_ld_we && (i_ld_idx == r_pf_tag)) begin
            r_pf_vld  <= 1'b0;
        end
    end
`endif

    assign fif.fetch_ready = (r_state == S_IDLE);
    assign fif.fetch_valid = r_valid;
    assign fif.fetch_inst  = r_inst;
    assign fif.fetch_fault = r_fault;

endmodule
